lc3_mem_if: RTL and testbench
=============================

LC3_MEM_IF -- requirements
Module: lc3_mem_if

Interface
REQ-001 Parameter: MAX_WAIT, 255, maximum cycles spent in a read or write access before timeout (1..255).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 global  input  16  global data bus value, source for MAR/MDR loads.
REQ-005 ld_mar  input  1  load MAR from global.
REQ-006 ld_mdr  input  1  load MDR from global (only when mio_en=0).
REQ-007 mio_en  input  1  request a memory access.
REQ-008 r_w  input  1  access type: 0 read, 1 write; sampled at access start.
REQ-009 gate_mdr  input  1  drive MDR onto bus_out.
REQ-010 bus_out  output  16  MDR when gate_mdr=1, else 16'h0000 (combinational).
REQ-011 mem_addr  output  16  current MAR value.
REQ-012 mem_wdata  output  16  current MDR value.
REQ-013 mem_req  output  1  memory request, registered.
REQ-014 mem_we  output  1  write strobe, registered; high only with mem_req.
REQ-015 mem_rdata  input  16  memory read data, valid when mem_ready=1.
REQ-016 mem_ready  input  1  memory completion handshake.
REQ-017 R  output  1  one-cycle access-complete pulse to the control FSM.
REQ-018 err  output  1  sticky timeout flag for the last access.

Function
REQ-019 States SHALL be IDLE, READ, WRITE, DONE.
REQ-020 IDLE: mio_en=1 SHALL move to READ (r_w=0) or WRITE (r_w=1) on the next edge and clear err and the wait counter.
REQ-021 READ/WRITE: mem_req=1; mem_we=1 only in WRITE; wait counter increments every cycle.
REQ-022 READ with mem_ready=1 at an edge: MDR <= mem_rdata on that edge, go to DONE.
REQ-023 WRITE with mem_ready=1 at an edge: go to DONE; MDR unchanged.
REQ-024 Counter reaching MAX_WAIT without mem_ready: set err=1, go to DONE, MDR unchanged.
REQ-025 mem_ready and timeout on the same edge: mem_ready wins, err stays 0.
REQ-026 R SHALL be 1 for exactly the first cycle in DONE; latency from mem_ready edge to R high is one cycle.
REQ-027 DONE SHALL return to IDLE only when mio_en=0; a held mio_en SHALL NOT start a second access.
REQ-028 ld_mar in IDLE or DONE: MAR <= global; ignored in READ/WRITE.
REQ-029 ld_mdr with mio_en=0 in IDLE or DONE: MDR <= global; ignored otherwise.
REQ-030 mem_ready while in IDLE or DONE SHALL be ignored.
REQ-031 mem_req and mem_we SHALL drop in the cycle after DONE is entered.
REQ-032 bus_out SHALL follow MDR combinationally whenever gate_mdr=1, including the cycle MDR is updated.

Reset
REQ-033 reset=1 SHALL immediately force state=IDLE, MAR=0, MDR=0, mem_req=0, mem_we=0, R=0, err=0, counter=0.
REQ-034 reset asserted mid-access SHALL abort it with mem_req dropping asynchronously and no MDR update.
REQ-035 After reset release, the first access SHALL start only on an edge where mio_en=1.

Verification
REQ-036 Read: global=16'h3000 + ld_mar; mio_en=1, r_w=0; mem_ready after 2 cycles with mem_rdata=16'hF0F0 -> mem_addr=16'h3000, MDR=16'hF0F0, R one cycle, gate_mdr -> bus_out=16'hF0F0.
REQ-037 Write: MAR=16'h0042, ld_mdr with global=16'hBEEF; mio_en=1, r_w=1 -> mem_req=mem_we=1, mem_wdata=16'hBEEF until mem_ready; R one pulse; err=0.
REQ-038 Timeout: MAX_WAIT=4, read, mem_ready held 0 -> DONE after 4 cycles in READ, err=1, MDR unchanged; next access clears err.
REQ-039 Held mio_en: mio_en high for 10 cycles, mem_ready after 1 -> exactly one mem_req burst and one R pulse.
REQ-040 Ignored loads: ld_mar with global=16'h1234 and ld_mdr during READ -> MAR and MDR unchanged until mem_ready.
REQ-041 Reset mid-access: reset during WRITE -> mem_req=0, mem_we=0 immediately; all registers 0; mem_ready afterward has no effect.

Source files
------------

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: MAR/MDR registers plus a request/ready handshake FSM with a timeout.
// Latency: mem_req rises one edge after mio_en is seen in IDLE; R pulses one cycle after the mem_ready edge.
// Backpressure: the access stalls in READ/WRITE until mem_ready or MAX_WAIT cycles; DONE holds until mio_en drops.
module lc3_mem_if #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] global,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        gate_mdr,
    output logic [15:0] bus_out,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        R,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] WAIT_LIM = 9'(MAX_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] mar;
    logic [15:0] mar_nxt;
    logic [15:0] mdr;
    logic [15:0] mdr_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic [8:0]  wait_inc;
    logic        req_q;
    logic        req_nxt;
    logic        we_q;
    logic        we_nxt;
    logic        r_q;
    logic        r_nxt;
    logic        err_q;
    logic        err_nxt;

    assign wait_inc = {1'b0, wait_cnt} + 9'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mar      <= 16'h0000;
            mdr      <= 16'h0000;
            wait_cnt <= 8'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            r_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            mar      <= mar_nxt;
            mdr      <= mdr_nxt;
            wait_cnt <= wait_cnt_nxt;
            req_q    <= req_nxt;
            we_q     <= we_nxt;
            r_q      <= r_nxt;
            err_q    <= err_nxt;
        end
    end

    // req/we/R are computed for the state being entered so they are clean flop outputs.
    always_comb begin
        state_nxt    = state;
        mar_nxt      = mar;
        mdr_nxt      = mdr;
        wait_cnt_nxt = wait_cnt;
        req_nxt      = 1'b0;
        we_nxt       = 1'b0;
        r_nxt        = 1'b0;
        err_nxt      = err_q;
        case (state)
            IDLE, DONE: begin
                if (ld_mar) begin
                    mar_nxt = global;
                end
                if (ld_mdr && !mio_en) begin
                    mdr_nxt = global;
                end
                if (state == IDLE) begin
                    if (mio_en) begin
                        state_nxt    = r_w ? WRITE : READ;
                        wait_cnt_nxt = 8'd0;
                        err_nxt      = 1'b0;
                        req_nxt      = 1'b1;
                        we_nxt       = r_w;
                    end
                end else if (!mio_en) begin
                    state_nxt = IDLE;
                end
            end
            READ, WRITE: begin
                wait_cnt_nxt = wait_inc[7:0];
                // mem_ready takes priority over a timeout landing on the same edge.
                if (mem_ready) begin
                    state_nxt = DONE;
                    r_nxt     = 1'b1;
                    if (state == READ) begin
                        mdr_nxt = mem_rdata;
                    end
                end else if (wait_inc >= WAIT_LIM) begin
                    state_nxt = DONE;
                    r_nxt     = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    req_nxt = 1'b1;
                    we_nxt  = (state == WRITE);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus_out   = gate_mdr ? mdr : 16'h0000;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign R         = r_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if with MAX_WAIT=4: per-cycle vector table plus reset and held-mio_en sequences.
module tb_lc3_mem_if;

    logic        clk;
    logic        reset;
    logic [15:0] global;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic        gate_mdr;
    logic [15:0] bus_out;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        R;
    logic        err;

    int total;
    int bad;

    lc3_mem_if #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .global    (global),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .gate_mdr  (gate_mdr),
        .bus_out   (bus_out),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .R         (R),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ld_mar;
        logic        ld_mdr;
        logic        mio_en;
        logic        r_w;
        logic        gate;
        logic        ready;
        logic [15:0] glob;
        logic [15:0] rdata;
        logic [15:0] e_bus;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_req;
        logic        e_we;
        logic        e_r;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic lm, input logic ld, input logic me, input logic rw,
                               input logic g, input logic rdy, input logic [15:0] gl,
                               input logic [15:0] rd, input logic [15:0] eb, input logic [15:0] ea,
                               input logic [15:0] ew, input logic erq, input logic ewe,
                               input logic er, input logic ee);
        vec_t t;
        t.ld_mar = lm; t.ld_mdr = ld; t.mio_en = me; t.r_w = rw; t.gate = g; t.ready = rdy;
        t.glob = gl; t.rdata = rd; t.e_bus = eb; t.e_addr = ea; t.e_wdata = ew;
        t.e_req = erq; t.e_we = ewe; t.e_r = er; t.e_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {12'h000, bus_out, mem_addr, mem_wdata, mem_req, mem_we, R, err};
    endfunction

    function automatic logic [63:0] exp_outs(input vec_t t);
        return {12'h000, t.e_bus, t.e_addr, t.e_wdata, t.e_req, t.e_we, t.e_r, t.e_err};
    endfunction

    task automatic idle_inputs();
        ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0; gate_mdr = 1'b0;
        mem_ready = 1'b0; global = 16'h0000; mem_rdata = 16'h0000;
    endtask

    initial begin
        int bursts;
        int pulses;
        logic prev_req;
        total = 0;
        bad   = 0;
        idle_inputs();

        //             lm ld me rw g  rdy glob      rdata     bus       addr      wdata   rq we R  err
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 16'h3000, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 16'h0000, 16'hF0F0, 16'hF0F0, 16'h3000, 16'hF0F0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'hF0F0, 16'h3000, 16'hF0F0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'hF0F0, 0, 0, 0, 0));
        // write of BEEF to 0042; r_w flipping mid-access must not matter
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 16'h0042, 16'h0000, 16'h0000, 16'h0042, 16'hF0F0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h1111, 16'h0000, 16'h0042, 16'hBEEF, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 16'h0000, 16'h1111, 16'h0000, 16'h0042, 16'hBEEF, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 16'h0000, 16'h2222, 16'h0000, 16'h0042, 16'hBEEF, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 0, 0, 0, 0));
        // timeout: four cycles in READ, then err sticks until the next access starts
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h0042, 16'h5A5A, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h5A5A, 0, 0, 0, 0));
        // mem_ready on the same edge the counter would time out
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h5A5A, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h5A5A, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 16'h0000, 16'h0C0C, 16'h0000, 16'h0042, 16'h0C0C, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h0C0C, 0, 0, 0, 0));
        // loads ignored while in READ; in DONE ld_mar works but ld_mdr is blocked by mio_en
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h0C0C, 1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0042, 16'h0C0C, 1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 0, 1, 16'h1234, 16'h7777, 16'h0000, 16'h0042, 16'h7777, 0, 0, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h7777, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h7777, 0, 0, 0, 0));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 64'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            ld_mar = vecs[i].ld_mar; ld_mdr = vecs[i].ld_mdr; mio_en = vecs[i].mio_en;
            r_w = vecs[i].r_w; gate_mdr = vecs[i].gate; mem_ready = vecs[i].ready;
            global = vecs[i].glob; mem_rdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), outs(), exp_outs(vecs[i]));
        end

        // held mio_en for ten cycles: one request burst and one R pulse
        idle_inputs();
        bursts = 0;
        pulses = 0;
        prev_req = mem_req;
        for (int i = 0; i < 10; i++) begin
            mio_en    = 1'b1;
            mem_ready = (i >= 1);
            mem_rdata = 16'hABCD;
            @(posedge clk);
            #1;
            if (mem_req && !prev_req) bursts++;
            if (R) pulses++;
            prev_req = mem_req;
        end
        idle_inputs();
        @(posedge clk);
        #1;
        check("held_bursts", 64'(bursts), 64'd1);
        check("held_r_pulses", 64'(pulses), 64'd1);
        check("held_mdr", 64'(mem_wdata), 64'hABCD);

        // reset during WRITE drops everything without a clock edge
        mio_en = 1'b1;
        r_w    = 1'b1;
        @(posedge clk);
        #1;
        check("write_started", {62'h0, mem_req, mem_we}, 64'h3);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", outs(), 64'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mio_en    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_ready_ignored", outs(), 64'h0);
        mio_en    = 1'b1;
        r_w       = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_start", {62'h0, mem_req, mem_we}, 64'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
